// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage, data memory read port and register file write port.
// The master modport drives the instruction and memory data; the slave is the writeback stage.
interface writeback_stage_if;
    logic        valid_in;
    logic        reg_write_en_in;
    logic        load;
    logic [1:0]  mem_to_reg;
    logic [2:0]  fun3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_address;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        reg_write_en_out;
    logic [4:0]  rd_out;
    logic [31:0] rd_wb_data;
    logic        stall_out;
    logic        err_timeout;
    logic        err_misalign;

    modport master (
        output valid_in, reg_write_en_in, load, mem_to_reg, fun3, rd,
               alu_result, pc_address, dmem_rdata, dmem_rvalid,
        input  reg_write_en_out, rd_out, rd_wb_data, stall_out,
               err_timeout, err_misalign
    );

    modport slave (
        input  valid_in, reg_write_en_in, load, mem_to_reg, fun3, rd,
               alu_result, pc_address, dmem_rdata, dmem_rvalid,
        output reg_write_en_out, rd_out, rd_wb_data, stall_out,
               err_timeout, err_misalign
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: selects the register write source, extracts load data, and waits
// (with timeout) for late data memory responses while stalling upstream.
module writeback_stage #(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    writeback_stage_if.slave wb
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    logic [0:0]  state_reg;
    logic [7:0]  cnt_reg;
    logic [4:0]  rd_cap_reg;
    logic [2:0]  fun3_cap_reg;
    logic [1:0]  off_cap_reg;
    logic        we_cap_reg;
    logic        we_out_reg;
    logic [4:0]  rd_out_reg;
    logic [31:0] wb_data_reg;
    logic        err_timeout_reg;
    logic        err_misalign_reg;

    logic [2:0]  ld_fun3;
    logic [1:0]  ld_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        ld_misalign;
    logic [31:0] alu_data;
    logic        timeout_hit;

    // While waiting, the load attributes come from the captured copy, not the live inputs.
    always_comb begin
        ld_fun3     = (state_reg == WAIT) ? fun3_cap_reg : wb.fun3;
        ld_off      = (state_reg == WAIT) ? off_cap_reg  : wb.alu_result[1:0];
        ld_byte     = wb.dmem_rdata[7:0];
        ld_data     = wb.dmem_rdata;
        ld_misalign = 1'b0;
        case (ld_off)
            2'd0:    ld_byte = wb.dmem_rdata[7:0];
            2'd1:    ld_byte = wb.dmem_rdata[15:8];
            2'd2:    ld_byte = wb.dmem_rdata[23:16];
            default: ld_byte = wb.dmem_rdata[31:24];
        endcase
        ld_half = ld_off[1] ? wb.dmem_rdata[31:16] : wb.dmem_rdata[15:0];
        case (ld_fun3)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100: ld_data = {24'd0, ld_byte};
            3'b001: begin
                ld_data     = {{16{ld_half[15]}}, ld_half};
                ld_misalign = ld_off[0];
            end
            3'b101: begin
                ld_data     = {16'd0, ld_half};
                ld_misalign = ld_off[0];
            end
            default: begin
                ld_data     = wb.dmem_rdata;
                ld_misalign = (ld_off != 2'd0);
            end
        endcase
    end

    always_comb begin
        case (wb.mem_to_reg)
            2'b01:   alu_data = ld_data;
            2'b10:   alu_data = wb.pc_address + 32'd4;
            default: alu_data = wb.alu_result;
        endcase
    end

    assign timeout_hit = (({1'b0, cnt_reg} + 9'd1) == TIMEOUT_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= 8'd0;
            rd_cap_reg       <= 5'd0;
            fun3_cap_reg     <= 3'd0;
            off_cap_reg      <= 2'd0;
            we_cap_reg       <= 1'b0;
            we_out_reg       <= 1'b0;
            rd_out_reg       <= 5'd0;
            wb_data_reg      <= 32'd0;
            err_timeout_reg  <= 1'b0;
            err_misalign_reg <= 1'b0;
        end else begin
            we_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wb.valid_in) begin
                        if (wb.load) begin
                            if (wb.dmem_rvalid) begin
                                if (ld_misalign) begin
                                    err_misalign_reg <= 1'b1;
                                end else if (wb.reg_write_en_in && wb.rd != 5'd0) begin
                                    we_out_reg  <= 1'b1;
                                    rd_out_reg  <= wb.rd;
                                    wb_data_reg <= ld_data;
                                end
                            end else begin
                                rd_cap_reg   <= wb.rd;
                                fun3_cap_reg <= wb.fun3;
                                off_cap_reg  <= wb.alu_result[1:0];
                                we_cap_reg   <= wb.reg_write_en_in;
                                cnt_reg      <= 8'd0;
                                state_reg    <= WAIT;
                            end
                        end else if (wb.reg_write_en_in && wb.rd != 5'd0) begin
                            we_out_reg  <= 1'b1;
                            rd_out_reg  <= wb.rd;
                            wb_data_reg <= alu_data;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still completes the load.
                    if (wb.dmem_rvalid) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 8'd0;
                        if (ld_misalign) begin
                            err_misalign_reg <= 1'b1;
                        end else if (we_cap_reg && rd_cap_reg != 5'd0) begin
                            we_out_reg  <= 1'b1;
                            rd_out_reg  <= rd_cap_reg;
                            wb_data_reg <= ld_data;
                        end
                    end else if (timeout_hit) begin
                        err_timeout_reg <= 1'b1;
                        state_reg       <= IDLE;
                        cnt_reg         <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign wb.reg_write_en_out = we_out_reg;
    assign wb.rd_out           = rd_out_reg;
    assign wb.rd_wb_data       = wb_data_reg;
    assign wb.stall_out        = (state_reg == WAIT) && !wb.dmem_rvalid;
    assign wb.err_timeout      = err_timeout_reg;
    assign wb.err_misalign     = err_misalign_reg;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: single-cycle vector table plus hand-built
// sequences for wait, timeout and reset-during-wait behaviour.
module tb_writeback_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    writeback_stage_if wb ();

    writeback_stage #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [1:0]  m2r;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb.valid_in        = 1'b0;
        wb.reg_write_en_in = 1'b0;
        wb.load            = 1'b0;
        wb.mem_to_reg      = 2'b00;
        wb.fun3            = 3'b000;
        wb.rd              = 5'd0;
        wb.alu_result      = 32'd0;
        wb.pc_address      = 32'd0;
        wb.dmem_rdata      = 32'd0;
        wb.dmem_rvalid     = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic issue_lw_wait(input logic [4:0] r);
        wb.valid_in        = 1'b1;
        wb.load            = 1'b1;
        wb.reg_write_en_in = 1'b1;
        wb.mem_to_reg      = 2'b01;
        wb.fun3            = 3'b010;
        wb.rd              = r;
        wb.alu_result      = 32'h0000_3000;
        wb.dmem_rvalid     = 1'b0;
        step();
        // Garbage on the instruction inputs while waiting must be ignored.
        wb.load            = 1'b0;
        wb.rd              = 5'd3;
        wb.mem_to_reg      = 2'b00;
        wb.alu_result      = 32'h0000_0BAD;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle_inputs();

        //          ld  m2r    f3      rd     we  alu           pc            rdata          ewe  erd    edata         emis
        vecs[0]  = '{1'b0, 2'b00, 3'b000, 5'd5,  1'b1, 32'h12345678, 32'h0,        32'h0,        1'b1, 5'd5,  32'h12345678, 1'b0};
        vecs[1]  = '{1'b1, 2'b01, 3'b000, 5'd1,  1'b1, 32'h00001003, 32'h0,        32'h80FF7F01, 1'b1, 5'd1,  32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 3'b100, 5'd2,  1'b1, 32'h00001003, 32'h0,        32'h80FF7F01, 1'b1, 5'd2,  32'h00000080, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 3'b101, 5'd3,  1'b1, 32'h00001002, 32'h0,        32'h80FF7F01, 1'b1, 5'd3,  32'h000080FF, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 3'b001, 5'd4,  1'b1, 32'h00001000, 32'h0,        32'h12348001, 1'b1, 5'd4,  32'hFFFF8001, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 3'b000, 5'd6,  1'b1, 32'h00001001, 32'h0,        32'h80FF7F01, 1'b1, 5'd6,  32'h0000007F, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 3'b010, 5'd8,  1'b1, 32'h00001000, 32'h0,        32'hDEADBEEF, 1'b1, 5'd8,  32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 3'b011, 5'd9,  1'b1, 32'h00002004, 32'h0,        32'h01020304, 1'b1, 5'd9,  32'h01020304, 1'b0};
        vecs[8]  = '{1'b0, 2'b10, 3'b000, 5'd1,  1'b1, 32'h0,        32'hFFFFFFFC, 32'h0,        1'b1, 5'd1,  32'h00000000, 1'b0};
        vecs[9]  = '{1'b0, 2'b11, 3'b000, 5'd31, 1'b1, 32'hA5A5A5A5, 32'h0,        32'h0,        1'b1, 5'd31, 32'hA5A5A5A5, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 3'b000, 5'd0,  1'b1, 32'h00000055, 32'h0,        32'h0,        1'b0, 5'd31, 32'hA5A5A5A5, 1'b0};
        vecs[11] = '{1'b0, 2'b00, 3'b000, 5'd10, 1'b0, 32'h00000077, 32'h0,        32'h0,        1'b0, 5'd31, 32'hA5A5A5A5, 1'b0};
        vecs[12] = '{1'b1, 2'b01, 3'b010, 5'd7,  1'b1, 32'h00001002, 32'h0,        32'h11111111, 1'b0, 5'd31, 32'hA5A5A5A5, 1'b1};
        vecs[13] = '{1'b1, 2'b01, 3'b101, 5'd7,  1'b1, 32'h00001001, 32'h0,        32'h22222222, 1'b0, 5'd31, 32'hA5A5A5A5, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 3'b000, 5'd12, 1'b1, 32'h00000000, 32'h0,        32'h0,        1'b1, 5'd12, 32'h00000000, 1'b1};

        // Reset state
        rst = 1'b0;
        #12;
        chk("reset_we",       {31'd0, wb.reg_write_en_out}, 32'd0);
        chk("reset_rd",       {27'd0, wb.rd_out},           32'd0);
        chk("reset_data",     wb.rd_wb_data,                32'd0);
        chk("reset_stall",    {31'd0, wb.stall_out},        32'd0);
        chk("reset_timeout",  {31'd0, wb.err_timeout},      32'd0);
        chk("reset_misalign", {31'd0, wb.err_misalign},     32'd0);
        step();
        rst = 1'b1;
        step();

        // Single-cycle vectors, memory data always present in the same cycle
        for (int i = 0; i < 15; i++) begin
            wb.valid_in        = 1'b1;
            wb.load            = vecs[i].ld;
            wb.mem_to_reg      = vecs[i].m2r;
            wb.fun3            = vecs[i].f3;
            wb.rd              = vecs[i].rd;
            wb.reg_write_en_in = vecs[i].we;
            wb.alu_result      = vecs[i].alu;
            wb.pc_address      = vecs[i].pc;
            wb.dmem_rdata      = vecs[i].rdata;
            wb.dmem_rvalid     = 1'b1;
            step();
            $display("vec %0d: we=%0b rd=%0d data=0x%08h mis=%0b", i,
                     wb.reg_write_en_out, wb.rd_out, wb.rd_wb_data, wb.err_misalign);
            chk($sformatf("vec%0d_we", i),   {31'd0, wb.reg_write_en_out}, {31'd0, vecs[i].exp_we});
            chk($sformatf("vec%0d_rd", i),   {27'd0, wb.rd_out},           {27'd0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_data", i), wb.rd_wb_data,                vecs[i].exp_data);
            chk($sformatf("vec%0d_mis", i),  {31'd0, wb.err_misalign},     {31'd0, vecs[i].exp_mis});
            chk($sformatf("vec%0d_stall", i),{31'd0, wb.stall_out},        32'd0);
        end
        idle_inputs();
        step();
        chk("idle_no_write", {31'd0, wb.reg_write_en_out}, 32'd0);

        // Late load: three stalled cycles, then data arrives
        do_reset();
        issue_lw_wait(5'd7);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("late_stall%0d", c), {31'd0, wb.stall_out},        32'd1);
            chk($sformatf("late_nowe%0d", c),  {31'd0, wb.reg_write_en_out}, 32'd0);
            if (c < 2) step();
        end
        wb.dmem_rdata  = 32'hCAFEBABE;
        wb.dmem_rvalid = 1'b1;
        #1;
        chk("late_stall_drop", {31'd0, wb.stall_out}, 32'd0);
        step();
        idle_inputs();
        $display("late load: we=%0b rd=%0d data=0x%08h", wb.reg_write_en_out, wb.rd_out, wb.rd_wb_data);
        chk("late_we",   {31'd0, wb.reg_write_en_out}, 32'd1);
        chk("late_rd",   {27'd0, wb.rd_out},           32'd7);
        chk("late_data", wb.rd_wb_data,                32'hCAFEBABE);
        chk("late_idle_stall", {31'd0, wb.stall_out},  32'd0);

        // Data on the final allowed wait cycle wins over timeout
        issue_lw_wait(5'd11);
        step(); step(); step();
        chk("edge_stall", {31'd0, wb.stall_out}, 32'd1);
        wb.dmem_rdata  = 32'h0BADF00D;
        wb.dmem_rvalid = 1'b1;
        step();
        idle_inputs();
        $display("edge load: we=%0b rd=%0d data=0x%08h to=%0b", wb.reg_write_en_out, wb.rd_out, wb.rd_wb_data, wb.err_timeout);
        chk("edge_we",      {31'd0, wb.reg_write_en_out}, 32'd1);
        chk("edge_rd",      {27'd0, wb.rd_out},           32'd11);
        chk("edge_data",    wb.rd_wb_data,                32'h0BADF00D);
        chk("edge_timeout", {31'd0, wb.err_timeout},      32'd0);

        // Reset mid-wait abandons the load
        issue_lw_wait(5'd13);
        step();
        #2;
        rst = 1'b0;
        #1;
        $display("reset mid-wait: we=%0b rd=%0d data=0x%08h stall=%0b", wb.reg_write_en_out, wb.rd_out, wb.rd_wb_data, wb.stall_out);
        chk("rstwait_rd",    {27'd0, wb.rd_out},    32'd0);
        chk("rstwait_data",  wb.rd_wb_data,         32'd0);
        chk("rstwait_stall", {31'd0, wb.stall_out}, 32'd0);
        step();
        rst = 1'b1;
        wb.valid_in    = 1'b0;
        wb.dmem_rdata  = 32'h77777777;
        wb.dmem_rvalid = 1'b1;
        step();
        chk("rstwait_nowe1", {31'd0, wb.reg_write_en_out}, 32'd0);
        step();
        chk("rstwait_nowe2", {31'd0, wb.reg_write_en_out}, 32'd0);
        chk("rstwait_data2", wb.rd_wb_data,                32'd0);
        idle_inputs();

        // Timeout: no response for four wait cycles
        issue_lw_wait(5'd14);
        step(); step(); step();
        chk("to_pre_flag",  {31'd0, wb.err_timeout}, 32'd0);
        chk("to_pre_stall", {31'd0, wb.stall_out},   32'd1);
        step();
        $display("timeout: we=%0b to=%0b stall=%0b", wb.reg_write_en_out, wb.err_timeout, wb.stall_out);
        chk("to_flag",  {31'd0, wb.err_timeout},      32'd1);
        chk("to_nowe",  {31'd0, wb.reg_write_en_out}, 32'd0);
        chk("to_stall", {31'd0, wb.stall_out},        32'd0);
        chk("to_rd_hold", {27'd0, wb.rd_out},         32'd0);
        idle_inputs();
        wb.dmem_rvalid = 1'b1;
        step();
        chk("to_late_nowe", {31'd0, wb.reg_write_en_out}, 32'd0);
        step();
        chk("to_sticky", {31'd0, wb.err_timeout}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
